// File: rtl/hist_pkg.sv
// Shared definitions for the histogram transmit path: FSM encodings,
// header field layout and the default word width.
package hist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_HEADER = 3'b010,
        ST_STREAM = 3'b100
    } state_t;

    localparam int N_BIN_LSB               = 0;
    localparam int ROW_LSB                 = 4;
    localparam int DEFAULT_HISTOGRAM_WIDTH = 16;

endpackage

// File: rtl/hist_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a pop in the same
// cycle as a push frees the slot the push needs when the FIFO is full.
module hist_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hist_flow_tx.sv
// Framing transmitter: buffers histogram bin words and emits one header word
// followed by storecycles data words per cell row over valid/ready.
module hist_flow_tx
    import hist_pkg::*;
#(
    parameter int HISTOGRAM_WIDTH = DEFAULT_HISTOGRAM_WIDTH,
    parameter int FIFO_DEPTH      = 16,
    parameter int ROW_CNT_WIDTH   = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [HISTOGRAM_WIDTH-1:0] data_in,
    input  logic                       data_valid_in,
    input  logic [15:0]                storecycles,
    input  logic [9:0]                 cellrows,
    input  logic [3:0]                 n_bin_exp,
    input  logic                       onoff,
    output logic [HISTOGRAM_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic                       overflow,
    output logic [ROW_CNT_WIDTH-1:0]   row_index
);
    localparam int RW = HISTOGRAM_WIDTH - ROW_LSB;

    state_t                        state;
    logic [15:0]                   word_cnt;
    logic [15:0]                   eff_sc;
    logic [ROW_LSB-1:0]            nbin_q;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [HISTOGRAM_WIDTH-1:0]    fifo_head;
    logic                          push_req;
    logic                          xfer;
    logic                          pop;
    logic                          drop;
    logic                          last_word;
    logic                          row_last;
    logic [RW+ROW_CNT_WIDTH-1:0]   row_ext;
    logic [HISTOGRAM_WIDTH-1:0]    hdr_word;

    hist_fifo #(
        .WIDTH (HISTOGRAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (!onoff),
        .push  (push_req),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign push_req  = data_valid_in && onoff;
    assign out_valid = (state == ST_HEADER) || ((state == ST_STREAM) && !fifo_empty);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (state == ST_STREAM);
    assign drop      = push_req && fifo_full && !pop;
    assign last_word = (word_cnt == eff_sc - 16'd1);
    assign row_last  = (row_index == ROW_CNT_WIDTH'(cellrows));

    // Zero-extend then slice, so the row field fits any output width.
    assign row_ext  = (RW + ROW_CNT_WIDTH)'(row_index);
    assign hdr_word = {row_ext[RW-1:0], nbin_q};

    assign out_data = (state == ST_HEADER) ? hdr_word :
                      (state == ST_STREAM) ? fifo_head : '0;
    assign out_sof  = (state == ST_HEADER) && (row_index == '0);
    assign out_eof  = (state == ST_STREAM) && last_word && row_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            eff_sc    <= '0;
            nbin_q    <= '0;
            row_index <= '0;
            overflow  <= 1'b0;
        end else if (!onoff) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            row_index <= '0;
            overflow  <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state  <= ST_HEADER;
                        nbin_q <= n_bin_exp;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        state    <= ST_STREAM;
                        word_cnt <= '0;
                        eff_sc   <= (storecycles == 16'd0) ? 16'd1 : storecycles;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + 16'd1;
                        if (last_word) begin
                            state     <= ST_IDLE;
                            row_index <= row_last ? '0 : row_index + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_flow_tx.sv
// Scoreboard bench for hist_flow_tx: directed stimulus queues expected beats,
// a negedge monitor pops and compares them on every handshake.
module tb_hist_flow_tx;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid_in;
    logic [15:0] storecycles;
    logic [9:0]  cellrows;
    logic [3:0]  n_bin_exp;
    logic        onoff;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic        overflow;
    logic [11:0] row_index;

    beat_t       sb[$];
    int          passed = 0;
    int          total  = 0;
    logic        ready_toggle = 1'b0;
    logic        hold_pend = 1'b0;
    logic [17:0] hold_prev = '0;

    hist_flow_tx dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .storecycles   (storecycles),
        .cellrows      (cellrows),
        .n_bin_exp     (n_bin_exp),
        .onoff         (onoff),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .overflow      (overflow),
        .row_index     (row_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input logic [15:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sof  = s;
        b.eof  = e;
        sb.push_back(b);
    endtask

    task automatic push_word(input logic [15:0] w);
        data_in       = w;
        data_valid_in = 1'b1;
        cyc();
        data_valid_in = 1'b0;
        cyc();
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        check("drain_done", sb.size(), 0);
        sb.delete();
        repeat (3) cyc();
    endtask

    always @(posedge clk) begin
        if (ready_toggle) begin
            #1 out_ready = ~out_ready;
        end
    end

    // Monitor: every handshake consumes one expected beat; a stalled beat must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_pend && onoff) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_data, out_sof, out_eof}, hold_prev);
            end
            hold_pend = onoff && out_valid && !out_ready;
            hold_prev = {out_data, out_sof, out_eof};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {14'd0, out_sof, out_eof, out_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    check("out_beat", {out_data, out_sof, out_eof}, {b.data, b.sof, b.eof});
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        data_in       = '0;
        data_valid_in = 1'b0;
        storecycles   = 16'd4;
        cellrows      = 10'd1;
        n_bin_exp     = 4'd4;
        onoff         = 1'b0;
        out_ready     = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sof_eof", {out_sof, out_eof}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_row_index", row_index, 0);
        #20;
        reset = 1'b0;
        cyc();

        // Basic frame: two rows of four words.
        onoff     = 1'b1;
        out_ready = 1'b1;
        exp_beat(16'h0004, 1, 0);
        for (int i = 1; i <= 4; i++) exp_beat(16'(i), 0, 0);
        exp_beat(16'h0014, 0, 0);
        for (int i = 5; i <= 8; i++) exp_beat(16'(i), 0, i == 8);
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        drain();
        check("basic_row_index", row_index, 0);
        check("basic_overflow", overflow, 0);

        // Same frame under 1010 backpressure.
        ready_toggle = 1'b1;
        exp_beat(16'h0004, 1, 0);
        for (int i = 1; i <= 4; i++) exp_beat(16'(i), 0, 0);
        exp_beat(16'h0014, 0, 0);
        for (int i = 5; i <= 8; i++) exp_beat(16'(i), 0, i == 8);
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        drain();
        ready_toggle = 1'b0;
        cyc();
        out_ready = 1'b1;
        check("bp_overflow", overflow, 0);
        check("bp_row_index", row_index, 0);

        // Overflow: 20 words into a 16-deep FIFO with the sink stalled.
        storecycles = 16'd16;
        cellrows    = 10'd0;
        out_ready   = 1'b0;
        for (int i = 1; i <= 16; i++) push_word(16'(i));
        check("ovf_before_17", overflow, 0);
        push_word(16'd17);
        check("ovf_after_17", overflow, 1);
        for (int i = 18; i <= 20; i++) push_word(16'(i));
        exp_beat(16'h0004, 1, 0);
        for (int i = 1; i <= 16; i++) exp_beat(16'(i), 0, i == 16);
        out_ready = 1'b1;
        drain();
        check("ovf_sticky", overflow, 1);
        onoff = 1'b0;
        cyc();
        cyc();
        check("ovf_cleared", overflow, 0);
        onoff = 1'b1;
        cyc();

        // Full FIFO with push and pop in the same cycle.
        storecycles = 16'd17;
        out_ready   = 1'b0;
        exp_beat(16'h0004, 1, 0);
        for (int i = 1; i <= 17; i++) exp_beat(16'h0100 + 16'(i), 0, i == 17);
        for (int i = 1; i <= 16; i++) push_word(16'h0100 + 16'(i));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        out_ready     = 1'b1;
        data_in       = 16'h0111;
        data_valid_in = 1'b1;
        cyc();
        data_valid_in = 1'b0;
        check("full_pop_overflow", overflow, 0);
        drain();
        check("full_pop_overflow_end", overflow, 0);

        // onoff drop after two of four data words.
        storecycles = 16'd4;
        cellrows    = 10'd1;
        out_ready   = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(16'h0020 + 16'(i));
        exp_beat(16'h0004, 1, 0);
        exp_beat(16'h0021, 0, 0);
        exp_beat(16'h0022, 0, 0);
        out_ready = 1'b1;
        repeat (3) cyc();
        onoff     = 1'b0;
        out_ready = 1'b0;
        cyc();
        check("off_valid", out_valid, 0);
        check("off_overflow", overflow, 0);
        check("off_row_index", row_index, 0);
        check("off_sb_empty", sb.size(), 0);
        cyc();
        onoff     = 1'b1;
        out_ready = 1'b1;
        exp_beat(16'h0004, 1, 0);
        for (int i = 1; i <= 4; i++) exp_beat(16'h0030 + 16'(i), 0, 0);
        for (int i = 1; i <= 4; i++) push_word(16'h0030 + 16'(i));
        drain();
        check("reenable_row_index", row_index, 1);

        // storecycles of zero behaves as one word per row.
        onoff = 1'b0;
        cyc();
        onoff       = 1'b1;
        storecycles = 16'd0;
        cellrows    = 10'd0;
        exp_beat(16'h0004, 1, 0);
        exp_beat(16'h0041, 0, 1);
        exp_beat(16'h0004, 1, 0);
        exp_beat(16'h0042, 0, 1);
        push_word(16'h0041);
        push_word(16'h0042);
        drain();
        check("sc0_row_index", row_index, 0);
        check("final_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hist_flow_tx.md
Name: hist_flow_tx

Overview:
- Transmit-side companion to the histogram cell engine.
- Accepts the sparse bin stream the histogram store phase produces: one word per valid pulse, at most one word every 2 cycles, storecycles words per cell row.
- Buffers the words, prefixes each cell row with a header word, and emits a framed packet stream over a valid/ready handshake toward the flow/bus output stage.
- Marks the start and end of each histogram frame.

Parameters:
- HISTOGRAM_WIDTH, 16, bin word width; also the output word width.
- FIFO_DEPTH, 16, input buffer depth in words; must be a power of two, at least 4.
- ROW_CNT_WIDTH, 12, width of the cell-row counter carried in the header.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  HISTOGRAM_WIDTH  histogram bin word.
- data_valid_in  in  1  data_in valid this cycle.
- storecycles  in  16  bin words per cell row; 0 is treated as 1.
- cellrows  in  10  cell rows per frame minus 1.
- n_bin_exp  in  4  log2 of bins per cell; copied into the header.
- onoff  in  1  enable; low means synchronous clear.
- out_data  out  HISTOGRAM_WIDTH  packet word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_sof  out  1  qualifies the first word (header) of the first row of a frame.
- out_eof  out  1  qualifies the last data word of the last row of a frame.
- overflow  out  1  sticky: an input word was dropped.
- row_index  out  ROW_CNT_WIDTH  current output cell row.

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; FSM in IDLE; all counters 0.
- Clock and reset:
  - Reset is asynchronous, active-high.
  - All other state changes on the rising edge of clk.
- Input side:
  - Word pushed when data_valid_in && onoff && FIFO not full.
  - If FIFO is full: word dropped and overflow set.
  - overflow clears only on reset or when onoff is low.
  - There is no input backpressure.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid is high and no transfer occurs, out_data, out_sof and out_eof hold stable.
  - out_valid never drops without a transfer, except on onoff low or reset.
- FSM states: IDLE, HEADER, STREAM.
  - IDLE: when the FIFO is non-empty, go to HEADER next cycle.
  - HEADER:
    - out_valid=1.
    - out_data = {row_index[11:0], n_bin_exp} for the 16-bit width. For other widths, row_index is zero-extended or truncated to fill HISTOGRAM_WIDTH-4 bits.
    - out_sof = (row_index==0).
    - On transfer go to STREAM and clear word_cnt.
  - STREAM:
    - out_valid = FIFO non-empty; out_data = FIFO head (first-word-fall-through).
    - On transfer: pop the FIFO and increment word_cnt.
    - On the transfer where word_cnt == eff_storecycles-1, return to IDLE.
    - out_eof = (word_cnt == eff_storecycles-1) && (row_index == cellrows).
- row_index:
  - Increments on the last data word transfer of a row.
  - Wraps to 0 after cellrows.
- Latency:
  - First input word to header out_valid: 2 cycles (push, then IDLE→HEADER).
  - Header accepted to first data word valid: 1 cycle.
- Simultaneous push and pop on the FIFO is allowed:
  - When full, the pop frees a slot, so the push is accepted and no drop occurs.
  - When empty, the pushed word is not visible at the output until the next cycle.
- onoff low, taking effect the next cycle:
  - FIFO flushed; FSM to IDLE; word_cnt, row_index and overflow cleared; out_valid low.
  - A partially sent row is abandoned with no out_eof.
- Reset mid-packet: same effect as onoff low, but immediate.
- storecycles changes are sampled only in HEADER, on the header transfer, as eff_storecycles.

Decomposition:
- Shared package (hist_pkg):
  - FSM state encodings (one-hot, 3 bits).
  - Header field offsets: N_BIN_LSB=0, ROW_LSB=4.
  - Default HISTOGRAM_WIDTH.
- Sub-module hist_fifo:
  - Synchronous first-word-fall-through FIFO with push, pop, full, empty and flush.
  - Pointer width $clog2(FIFO_DEPTH)+1.

Test Plan:
- Basic frame:
  - Stimulus: storecycles=4, cellrows=1, n_bin_exp=4, out_ready=1; push 8 words 0x0001..0x0008, one every 2 cycles.
  - Response: 0x0004(sof), 0x0001..0x0004, 0x0014, 0x0005..0x0008; eof on 0x0008; row_index returns to 0.
- Backpressure:
  - Stimulus: same as basic frame, with out_ready toggling 1010….
  - Response: identical word sequence; out_data stable while stalled; no overflow.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, out_ready=0; push 20 words.
  - Response: overflow=1 after word 17. On releasing out_ready: header, then exactly 16 words 0x0001..0x0010.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 in STREAM, push in the same cycle.
  - Response: no drop; overflow stays 0.
- onoff drop mid-row:
  - Stimulus: onoff low after 2 of 4 data words.
  - Response: next cycle out_valid=0, overflow=0, row_index=0. Re-enable and push 4 words → header 0x0004 with sof.
- storecycles=0:
  - Stimulus: storecycles=0, cellrows=0; push 2 words.
  - Response: header, word 1 with eof, header, word 2 with eof.
